// File: rtl/raytrace_pkg.sv
// Shared types and helpers for the ray-trace frame sequencer.
// The optional cycle counter is enabled with RAYTRACE_PERF_EN.
package raytrace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_EMIT,
        ST_DONE
    } state_t;

    localparam int DEPTH_W_DEF = 16;
    localparam int SPH_W_MAX   = 8;

    typedef logic [DEPTH_W_DEF-1:0] depth_t;
    localparam depth_t DEPTH_MAX = '1;

    typedef struct packed {
        logic                 hit;
        logic [SPH_W_MAX-1:0] sphere;
        depth_t               depth;
    } pix_result_t;

    // Index/coordinate width; at least one bit even for a single entry.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raytrace_if.sv
// Sequencer-side bus: intersection request/result plus pixel result handshake.
interface raytrace_if #(
    parameter int SPH_W   = 3,
    parameter int DEPTH_W = 16,
    parameter int X_W     = 10,
    parameter int Y_W     = 9
);
    logic               isect_req;
    logic               isect_ack;
    logic [SPH_W-1:0]   sph_idx;
    logic [X_W-1:0]     px_x;
    logic [Y_W-1:0]     px_y;
    logic               res_valid;
    logic               res_hit;
    logic [DEPTH_W-1:0] res_depth;
    logic               pix_valid;
    logic               pix_ready;
    logic               pix_hit;
    logic [SPH_W-1:0]   pix_sphere;
    logic [DEPTH_W-1:0] pix_depth;

    modport master (
        output isect_req, sph_idx, px_x, px_y,
        input  isect_ack, res_valid, res_hit, res_depth,
        output pix_valid, pix_hit, pix_sphere, pix_depth,
        input  pix_ready
    );

    modport slave (
        input  isect_req, sph_idx, px_x, px_y,
        output isect_ack, res_valid, res_hit, res_depth,
        input  pix_valid, pix_hit, pix_sphere, pix_depth,
        output pix_ready
    );
endinterface

// File: rtl/raytrace_nearest_hit.sv
// Nearest-hit tracker: keeps the closest hit depth/index seen for the current pixel.
module raytrace_nearest_hit #(
    parameter int SPH_W   = 3,
    parameter int DEPTH_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               update,
    input  logic               res_hit,
    input  logic [DEPTH_W-1:0] res_depth,
    input  logic [SPH_W-1:0]   res_idx,
    output logic               best_hit,
    output logic [SPH_W-1:0]   best_idx,
    output logic [DEPTH_W-1:0] best_depth
);

    logic closer;

    // Strict compare: on equal depth the earlier (lower) index is kept.
    assign closer = res_hit && (res_depth < best_depth);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_hit   <= 1'b0;
            best_idx   <= '0;
            best_depth <= '1;
        end else if (clear) begin
            best_hit   <= 1'b0;
            best_idx   <= '0;
            best_depth <= '1;
        end else if (update && closer) begin
            best_hit   <= 1'b1;
            best_idx   <= res_idx;
            best_depth <= res_depth;
        end
    end

endmodule

// File: rtl/raytrace_sequencer.sv
// Frame-level control FSM: walks every pixel, issues one intersection per sphere,
// emits the nearest hit. Define RAYTRACE_PERF_EN to add the perf_cycles counter.
module raytrace_sequencer
    import raytrace_pkg::*;
#(
    parameter int NUM_SPHERES = 8,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int DEPTH_W     = DEPTH_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic frame_done,
    raytrace_if.master bus
`ifdef RAYTRACE_PERF_EN
    ,
    output logic [31:0] perf_cycles
`endif
);

    localparam int SPH_W = width_of(NUM_SPHERES);
    localparam int X_W   = width_of(H_RES);
    localparam int Y_W   = width_of(V_RES);

    localparam logic [SPH_W-1:0] SPH_LAST = SPH_W'(NUM_SPHERES - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_RES - 1);

    state_t state, state_next;

    logic [X_W-1:0]   px_x;
    logic [Y_W-1:0]   px_y;
    logic [SPH_W-1:0] sph_idx;

    logic frame_start;
    logic px_clr, px_adv;
    logic sph_clr, sph_inc;
    logic best_clr, best_upd;

    logic               best_hit;
    logic [SPH_W-1:0]   best_idx;
    logic [DEPTH_W-1:0] best_depth;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        px_clr      = 1'b0;
        px_adv      = 1'b0;
        sph_clr     = 1'b0;
        sph_inc     = 1'b0;
        best_clr    = 1'b0;
        best_upd    = 1'b0;

        if (abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
            px_clr     = 1'b1;
            sph_clr    = 1'b1;
            best_clr   = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_next  = ST_ISSUE;
                        frame_start = 1'b1;
                        px_clr      = 1'b1;
                        sph_clr     = 1'b1;
                        best_clr    = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.isect_ack) state_next = ST_WAIT_RES;
                end
                ST_WAIT_RES: begin
                    if (bus.res_valid) begin
                        best_upd = 1'b1;
                        if (sph_idx == SPH_LAST) begin
                            state_next = ST_EMIT;
                        end else begin
                            sph_inc    = 1'b1;
                            state_next = ST_ISSUE;
                        end
                    end
                end
                ST_EMIT: begin
                    if (bus.pix_ready) begin
                        sph_clr  = 1'b1;
                        best_clr = 1'b1;
                        if ((px_x == X_LAST) && (px_y == Y_LAST)) begin
                            px_clr     = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            px_adv     = 1'b1;
                            state_next = ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_x    <= '0;
            px_y    <= '0;
            sph_idx <= '0;
        end else begin
            if (px_clr) begin
                px_x <= '0;
                px_y <= '0;
            end else if (px_adv) begin
                if (px_x == X_LAST) begin
                    px_x <= '0;
                    px_y <= px_y + Y_W'(1);
                end else begin
                    px_x <= px_x + X_W'(1);
                end
            end

            if (sph_clr)      sph_idx <= '0;
            else if (sph_inc) sph_idx <= sph_idx + SPH_W'(1);
        end
    end

    raytrace_nearest_hit #(
        .SPH_W   (SPH_W),
        .DEPTH_W (DEPTH_W)
    ) u_nearest_hit (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (best_clr),
        .update     (best_upd),
        .res_hit    (bus.res_hit),
        .res_depth  (bus.res_depth),
        .res_idx    (sph_idx),
        .best_hit   (best_hit),
        .best_idx   (best_idx),
        .best_depth (best_depth)
    );

    // Outputs decode straight from registered state so they stay stable across a stalled handshake.
    assign busy           = (state != ST_IDLE);
    assign frame_done     = (state == ST_DONE);
    assign bus.isect_req  = (state == ST_ISSUE);
    assign bus.pix_valid  = (state == ST_EMIT);
    assign bus.sph_idx    = sph_idx;
    assign bus.px_x       = px_x;
    assign bus.px_y       = px_y;
    assign bus.pix_hit    = best_hit;
    assign bus.pix_sphere = best_idx;
    assign bus.pix_depth  = best_depth;

`ifdef RAYTRACE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (frame_start) begin
            perf_cycles <= '0;
        end else if ((state != ST_IDLE) && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_raytrace_sequencer.sv
// Directed bench for raytrace_sequencer on a 2x2 frame with three spheres.
module tb_raytrace_sequencer;
    import raytrace_pkg::*;

    localparam int NUM_SPHERES = 3;
    localparam int H_RES       = 2;
    localparam int V_RES       = 2;
    localparam int DEPTH_W     = 16;
    localparam int SPH_W       = 2;
    localparam int X_W         = 1;
    localparam int Y_W         = 1;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic busy, frame_done;
`ifdef RAYTRACE_PERF_EN
    logic [31:0] perf_cycles;
`endif

    raytrace_if #(.SPH_W(SPH_W), .DEPTH_W(DEPTH_W), .X_W(X_W), .Y_W(Y_W)) bus ();

    raytrace_sequencer #(
        .NUM_SPHERES (NUM_SPHERES),
        .H_RES       (H_RES),
        .V_RES       (V_RES),
        .DEPTH_W     (DEPTH_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
`ifdef RAYTRACE_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_count = 0;
    int busy_cycles = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_count++;
        if (busy === 1'b1) busy_cycles++;
    end

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_for_req();
        int k = 0;
        while (bus.isect_req !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check_value("isect_req_seen", 32'(bus.isect_req), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check_value("start_busy", 32'(busy), 32'd1);
        check_value("start_pos", {bus.px_x, bus.px_y, bus.sph_idx}, 32'd0);
    endtask

    task automatic serve_sphere(input int s, input int x, input int y,
                                input logic hit, input logic [15:0] depth, input int ack_delay);
        logic [4:0] held;
        wait_for_req();
        held = {1'b1, SPH_W'(s), X_W'(x), Y_W'(y)};
        check_value("req_pos", {bus.isect_req, bus.sph_idx, bus.px_x, bus.px_y}, held);
        for (int i = 0; i < ack_delay; i++) begin
            step();
            check_value("req_held", {bus.isect_req, bus.sph_idx, bus.px_x, bus.px_y}, held);
        end
        bus.isect_ack = 1'b1;
        step();
        bus.isect_ack = 1'b0;
        check_value("req_drop", 32'(bus.isect_req), 32'd0);
        bus.res_valid = 1'b1;
        bus.res_hit   = hit;
        bus.res_depth = depth;
        step();
        bus.res_valid = 1'b0;
        bus.res_hit   = 1'b0;
        bus.res_depth = '0;
    endtask

    task automatic serve_spheres(input int x, input int y, input logic [2:0] hits,
                                 input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [15:0] d2, input int ack_delay);
        logic [15:0] d [3];
        d = '{d0, d1, d2};
        for (int s = 0; s < NUM_SPHERES; s++)
            serve_sphere(s, x, y, hits[s], d[s], ack_delay);
    endtask

    task automatic serve_pixel(input int x, input int y, input logic [2:0] hits,
                               input logic [15:0] d0, input logic [15:0] d1,
                               input logic [15:0] d2, input int ack_delay,
                               input int ready_delay, input pix_result_t exp);
        logic [31:0] held;
        int k = 0;
        serve_spheres(x, y, hits, d0, d1, d2, ack_delay);
        while (bus.pix_valid !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check_value("pix_valid", 32'(bus.pix_valid), 32'd1);
        check_value("pix_hit", 32'(bus.pix_hit), 32'(exp.hit));
        check_value("pix_sphere", 32'(bus.pix_sphere), 32'(exp.sphere));
        check_value("pix_depth", 32'(bus.pix_depth), 32'(exp.depth));
        held = {bus.pix_valid, bus.pix_hit, bus.pix_sphere, bus.pix_depth, bus.px_x, bus.px_y};
        for (int i = 0; i < ready_delay; i++) begin
            step();
            check_value("pix_held", {bus.pix_valid, bus.pix_hit, bus.pix_sphere, bus.pix_depth,
                                     bus.px_x, bus.px_y},
                        {1'b1, exp.hit, SPH_W'(exp.sphere), exp.depth, X_W'(x), Y_W'(y)});
        end
        check_value("pix_stable", {bus.pix_valid, bus.pix_hit, bus.pix_sphere, bus.pix_depth,
                                   bus.px_x, bus.px_y}, held);
        bus.pix_ready = 1'b1;
        step();
        bus.pix_ready = 1'b0;
    endtask

    localparam pix_result_t MISS = '{hit: 1'b0, sphere: 8'd0, depth: DEPTH_MAX};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        bus.isect_ack = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_hit   = 1'b0;
        bus.res_depth = '0;
        bus.pix_ready = 1'b0;
        #12;

        // Reset values
        check_value("rst_ctrl", {busy, frame_done, bus.isect_req, bus.pix_valid, bus.pix_hit}, 32'd0);
        check_value("rst_pos", {bus.px_x, bus.px_y, bus.sph_idx, bus.pix_sphere}, 32'd0);
        check_value("rst_depth", 32'(bus.pix_depth), 32'hFFFF);
        #3 rst_n = 1'b1;
        step();

        // Full frame of misses at minimum latency
        busy_cycles = 0;
        pulse_start();
        serve_pixel(0, 0, 3'b000, 16'd5, 16'd6, 16'd7, 0, 0, MISS);
        serve_pixel(1, 0, 3'b000, 16'd5, 16'd6, 16'd7, 0, 0, MISS);
        serve_pixel(0, 1, 3'b000, 16'd5, 16'd6, 16'd7, 0, 0, MISS);
        serve_pixel(1, 1, 3'b000, 16'd5, 16'd6, 16'd7, 0, 0, MISS);
        check_value("done_pulse", {frame_done, busy}, 32'b11);
        step();
        check_value("done_fall", {frame_done, busy}, 32'b00);
        check_value("fd_count1", 32'(fd_count), 32'd1);
        check_value("busy_cycles", 32'(busy_cycles), 32'd29);
`ifdef RAYTRACE_PERF_EN
        check_value("perf_done", perf_cycles, 32'd29);
        step();
        step();
        step();
        check_value("perf_hold", perf_cycles, 32'd29);
`endif

        // Nearest-hit selection, tie handling and stalled handshakes
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef RAYTRACE_PERF_EN
        check_value("perf_clear", perf_cycles, 32'd0);
`endif
        serve_pixel(0, 0, 3'b111, 16'd30, 16'd12, 16'd12, 0, 0,
                    '{hit: 1'b1, sphere: 8'd1, depth: 16'd12});
        serve_pixel(1, 0, 3'b101, 16'd7, 16'd0, 16'd5, 5, 3,
                    '{hit: 1'b1, sphere: 8'd2, depth: 16'd5});
        serve_pixel(0, 1, 3'b011, 16'd100, 16'd100, 16'd1, 0, 0,
                    '{hit: 1'b1, sphere: 8'd0, depth: 16'd100});
        serve_pixel(1, 1, 3'b100, 16'd3, 16'd3, 16'hFFFE, 0, 1,
                    '{hit: 1'b1, sphere: 8'd2, depth: 16'hFFFE});
        check_value("done_pulse2", 32'(frame_done), 32'd1);
        step();
        check_value("fd_count2", 32'(fd_count), 32'd2);

        // start with abort in IDLE stays idle
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_value("start_abort_idle", {busy, bus.isect_req}, 32'd0);

        // Abort during WAIT_RES of pixel (1,0)
        pulse_start();
        serve_pixel(0, 0, 3'b000, 16'd1, 16'd1, 16'd1, 0, 0, MISS);
        serve_sphere(0, 1, 0, 1'b1, 16'd3, 0);
        wait_for_req();
        bus.isect_ack = 1'b1;
        step();
        bus.isect_ack = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_value("abort_idle", {busy, bus.isect_req, bus.pix_valid, frame_done}, 32'd0);
        check_value("abort_clr", {bus.px_x, bus.px_y, bus.sph_idx}, 32'd0);
        check_value("abort_best", {bus.pix_hit, bus.pix_depth}, {1'b0, 16'hFFFF});
        step();
        step();
        check_value("abort_no_done", 32'(fd_count), 32'd2);
        pulse_start();
        serve_pixel(0, 0, 3'b000, 16'd1, 16'd1, 16'd1, 0, 0, MISS);

        // Asynchronous reset in EMIT, then spurious result in IDLE
        serve_spheres(1, 0, 3'b001, 16'd9, 16'd1, 16'd1, 0);
        check_value("emit_valid", {bus.pix_valid, bus.pix_hit, bus.pix_depth}, {1'b1, 1'b1, 16'd9});
        #2 rst_n = 1'b0;
        #1;
        check_value("async_rst", {busy, bus.pix_valid, bus.pix_hit, bus.px_x}, 32'd0);
        check_value("async_rst_depth", 32'(bus.pix_depth), 32'hFFFF);
        #3 rst_n = 1'b1;
        step();
        bus.res_valid = 1'b1;
        bus.res_hit   = 1'b1;
        bus.res_depth = 16'd1;
        step();
        step();
        bus.res_valid = 1'b0;
        bus.res_hit   = 1'b0;
        check_value("spurious_ctrl", {busy, bus.isect_req, bus.pix_valid, bus.pix_hit, bus.sph_idx},
                    32'd0);
        check_value("spurious_depth", 32'(bus.pix_depth), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
